ps2_key_queue: RTL and testbench
================================

PS2_KEY_QUEUE -- requirements
Module: ps2_key_queue

Interface
REQ-001 Parameter DEPTH, default 16, queue entries; power of two, 2..64.
REQ-002 Parameter REPEAT_FILTER, default 1; 1 = drop typematic repeats, 0 = pass every make code.
REQ-003 Clock_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset; sampled on Clock_50 rising edge.
REQ-005 PS2_code  input  8  scan code from the PS2 controller.
REQ-006 PS2_code_ready  input  1  level from the PS2 controller; a rising edge marks a new code.
REQ-007 PS2_make_code  input  1  1 = make (press), 0 = break (release) for the current PS2_code.
REQ-008 Key_read  input  1  consumer pop strobe, one entry per asserted cycle.
REQ-009 Clear_overflow  input  1  clears Overflow.
REQ-010 Key_code  output  8  scan code at the queue head (show-ahead).
REQ-011 Key_caps  output  1  caps attribute of the head entry.
REQ-012 Key_valid  output  1  queue non-empty.
REQ-013 Key_count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 Shift_caps  output  1  current caps mode.
REQ-015 Overflow  output  1  sticky flag: a printable key was dropped because the queue was full.

Function
REQ-016 The block shall keep a 1-cycle delayed copy of PS2_code_ready and detect a rising edge as ready=1 and delayed=0.
REQ-017 FSM states shall be S_WAIT and S_EVAL; S_WAIT goes to S_EVAL on a detected edge, latching PS2_code and PS2_make_code; S_EVAL always returns to S_WAIT after one cycle.
REQ-018 Edges cannot occur in S_EVAL, since ready must fall and rise again; the design shall not buffer a second edge.
REQ-019 In S_EVAL, a make 0x12 (left shift) shall set Shift_caps=1; a make 0x59 (right shift) shall set Shift_caps=0; neither is enqueued.
REQ-020 In S_EVAL, a break code equal to the last-enqueued register shall clear that register to 0x00; all break codes are otherwise discarded.
REQ-021 In S_EVAL, any other make code shall be a printable key.
REQ-022 When REPEAT_FILTER=1, a printable key equal to a nonzero last-enqueued register shall be discarded.
REQ-023 Otherwise the printable key shall be pushed as {Shift_caps, code}, and the last-enqueued register shall update to that code.
REQ-024 Push latency: an edge detected in cycle N shall be evaluated in cycle N+1, and the entry becomes visible (Key_valid, Key_count) in cycle N+2.
REQ-025 Pop: Key_read with Key_valid=1 shall advance the head next cycle; Key_read with Key_valid=0 shall be ignored with no underflow or pointer change.
REQ-026 Push and pop in the same cycle shall leave Key_count unchanged; this holds at full, where the push is accepted.
REQ-027 A push at full without a same-cycle pop shall drop the key, set Overflow=1, and leave the queue and last-enqueued register unchanged.
REQ-028 Overflow shall stay 1 until Clear_overflow=1.
REQ-029 If Clear_overflow and a new overflow occur in the same cycle, Overflow shall remain 1.
REQ-030 Read and write pointers shall wrap modulo DEPTH.
REQ-031 Key_count shall be a separate counter, not derived from pointer difference.
REQ-032 Key_code and Key_caps shall be don't-care when Key_valid=0, but shall be deterministic (no X after reset).

Reset
REQ-033 Reset=1 shall force, on the next edge: FSM=S_WAIT, both pointers=0, Key_count=0, Key_valid=0, Shift_caps=0, Overflow=0, last-enqueued=0x00, delayed ready=0, Key_code=0x00, Key_caps=0.
REQ-034 Reset asserted mid-S_EVAL shall discard the pending code, and no push shall occur.
REQ-035 Reset shall take priority over all inputs; queue storage contents need not be cleared.

Verification
REQ-036 Scenario: edge with make 0x1C in cycle N -> Key_valid=1, Key_code=0x1C, Key_caps=0, Key_count=1 in cycle N+2.
REQ-037 Scenario: make 0x12, then make 0x1C, break 0x1C, make 0x1C -> two entries {1,0x1C}, {1,0x1C}; Shift_caps=1.
REQ-038 Scenario: make 0x1C three times with no break (REPEAT_FILTER=1) -> exactly one entry.
REQ-039 Scenario: REPEAT_FILTER=0 with the same stimulus -> three entries.
REQ-040 Scenario: 17 distinct make codes with no reads -> Key_count=16, Overflow=1, head = first code; Clear_overflow pulse -> Overflow=0.
REQ-041 Scenario: queue full, Key_read coincides with a push in S_EVAL -> Key_count stays 16, Overflow stays 0, new code at tail.
REQ-042 Scenario: Key_read on empty queue -> Key_count stays 0.
REQ-043 Scenario: Reset asserted in the S_EVAL cycle -> Key_count=0 and Key_valid=0 afterwards, with no entry.

Source files
------------

// File: rtl/ps2_key_queue.sv
// -----------------------------------------------------------------------------
// ps2_key_queue
//
// Takes scan codes from a PS2 controller and turns them into a queue of
// printable keystrokes for a consumer.
//   - A rising edge on PS2_code_ready marks a new code. The code and its
//     make/break flag are latched, then evaluated in the following cycle.
//   - Left shift make (0x12) turns caps mode on. Right shift make (0x59) turns
//     caps mode off. Neither one is queued.
//   - A break code only re-arms the repeat filter, and only when it matches
//     the last queued code. Every other break code is ignored.
//   - Any other make code is printable and is queued as {caps, code}. With
//     REPEAT_FILTER=1, typematic repeats of the last queued key are dropped.
//   - The queue is a show-ahead FIFO. A printable key that arrives while the
//     queue is full, with no pop in the same cycle, is dropped and sets the
//     sticky Overflow flag.
//
// Parameters
//   DEPTH          queue entries, power of two in 2..64
//   REPEAT_FILTER  1 = drop typematic repeats, 0 = queue every make code
//
// Ports
//   Clock_50        in   sole clock, rising edge
//   Reset           in   synchronous, active-high
//   PS2_code        in   8-bit scan code
//   PS2_code_ready  in   level; a rising edge marks a new code
//   PS2_make_code   in   1 = make (press), 0 = break (release)
//   Key_read        in   pop strobe, one entry per asserted cycle
//   Clear_overflow  in   clears Overflow
//   Key_code        out  scan code at the queue head
//   Key_caps        out  caps attribute of the head entry
//   Key_valid       out  queue non-empty
//   Key_count       out  occupancy, 0..DEPTH
//   Shift_caps      out  current caps mode
//   Overflow        out  sticky: a printable key was dropped at full
// -----------------------------------------------------------------------------
module ps2_key_queue #(
  parameter int DEPTH         = 16,
  parameter int REPEAT_FILTER = 1
) (
  input  logic                   Clock_50,
  input  logic                   Reset,
  input  logic [7:0]             PS2_code,
  input  logic                   PS2_code_ready,
  input  logic                   PS2_make_code,
  input  logic                   Key_read,
  input  logic                   Clear_overflow,
  output logic [7:0]             Key_code,
  output logic                   Key_caps,
  output logic                   Key_valid,
  output logic [$clog2(DEPTH):0] Key_count,
  output logic                   Shift_caps,
  output logic                   Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;

  typedef enum logic {
    S_WAIT,
    S_EVAL
  } state_t;

  typedef struct packed {
    logic       caps;
    logic [7:0] code;
  } entry_t;

  state_t          state, state_n;
  logic            ready_d;
  logic            ready_edge;
  logic [7:0]      code_q;
  logic            make_q;
  logic [7:0]      last_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  entry_t          mem [DEPTH];

  logic            is_eval;
  logic            shift_set, shift_clr;
  logic            brk_match;
  logic            push_req;
  logic            full;
  logic            do_push, do_pop;
  logic            ovf_set;

  assign ready_edge = PS2_code_ready & ~ready_d;

  // ---------------------------------------------------------------------------
  // FSM state register, edge detector and latched code
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge value of every other register, exactly like the hardware.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state   <= S_WAIT;
      ready_d <= 1'b0;
      code_q  <= 8'h00;
      make_q  <= 1'b0;
    end else begin
      state   <= state_n;
      ready_d <= PS2_code_ready;
      if (state == S_WAIT && ready_edge) begin
        code_q <= PS2_code;
        make_q <= PS2_make_code;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and evaluation decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    is_eval   = 1'b0;
    shift_set = 1'b0;
    shift_clr = 1'b0;
    brk_match = 1'b0;
    push_req  = 1'b0;

    case (state)
      S_WAIT: if (ready_edge) state_n = S_EVAL;
      S_EVAL: begin
        state_n = S_WAIT;
        is_eval = 1'b1;
      end
      default: state_n = S_WAIT;
    endcase

    if (is_eval) begin
      if (!make_q) begin
        brk_match = (code_q == last_q);
      end else if (code_q == CODE_LSHIFT) begin
        shift_set = 1'b1;
      end else if (code_q == CODE_RSHIFT) begin
        shift_clr = 1'b1;
      end else begin
        // Zero in last_q means "nothing held", so a repeat needs a nonzero match.
        push_req = !((REPEAT_FILTER != 0) && (last_q != 8'h00) && (code_q == last_q));
      end
    end
  end

  // A pop frees a slot in the same cycle, so a push at full is still accepted.
  assign full    = (Key_count == CW'(DEPTH));
  assign do_pop  = Key_read && Key_valid;
  assign do_push = push_req && (!full || do_pop);
  assign ovf_set = push_req && full && !do_pop;

  // ---------------------------------------------------------------------------
  // Queue pointers, occupancy, flags and last-enqueued register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Key_count  <= '0;
      Shift_caps <= 1'b0;
      Overflow   <= 1'b0;
      last_q     <= 8'h00;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({do_push, do_pop})
        2'b10:   Key_count <= Key_count + CW'(1);
        2'b01:   Key_count <= Key_count - CW'(1);
        default: Key_count <= Key_count;
      endcase

      if (shift_set)      Shift_caps <= 1'b1;
      else if (shift_clr) Shift_caps <= 1'b0;

      // A fresh overflow wins over a clear requested in the same cycle.
      if (ovf_set)             Overflow <= 1'b1;
      else if (Clear_overflow) Overflow <= 1'b0;

      if (do_push)        last_q <= code_q;
      else if (brk_match) last_q <= 8'h00;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue storage
  // ---------------------------------------------------------------------------
  // NOTE: storage has no reset. It is only read when Key_count says the entry
  // was written, so clearing it would cost logic and buy nothing.
  always_ff @(posedge Clock_50) begin
    if (!Reset && do_push) begin
      mem[wr_ptr] <= '{caps: Shift_caps, code: code_q};
    end
  end

  // Head outputs are gated by Key_valid, so uninitialised storage never leaks
  // X onto them after reset.
  assign Key_valid = (Key_count != '0);
  assign Key_code  = Key_valid ? mem[rd_ptr].code : 8'h00;
  assign Key_caps  = Key_valid ? mem[rd_ptr].caps : 1'b0;

endmodule

// File: tb/tb_ps2_key_queue.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_queue
//
// Self-checking bench for ps2_key_queue.
//   - A behavioural reference model keeps the expected queue contents as a
//     SystemVerilog queue. A code's effect appears at the end of the cycle
//     after its ready edge.
//   - A monitor compares the DUT's outputs against the model on every falling
//     edge.
//   - The main sequence runs the directed scenarios first, then a randomized
//     phase with random codes, reads and overflow clears.
//   - A second instance with REPEAT_FILTER=0 shares the stimulus and is used
//     to check that typematic repeats pass through when filtering is off.
// -----------------------------------------------------------------------------
module tb_ps2_key_queue;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    ps2_code = 8'h00;
  logic          ps2_ready = 1'b0;
  logic          ps2_make = 1'b0;
  logic          key_read = 1'b0;
  logic          clear_ovf = 1'b0;

  logic [7:0]    key_code;
  logic          key_caps, key_valid, shift_caps, overflow;
  logic [CW-1:0] key_count;

  logic          nf_read = 1'b0;
  logic [7:0]    nf_code;
  logic          nf_caps, nf_valid, nf_shift, nf_ovf;
  logic [CW-1:0] nf_count;

  always #5 clk = ~clk;

  ps2_key_queue #(.DEPTH(DEPTH), .REPEAT_FILTER(1)) dut (
    .Clock_50       (clk),
    .Reset          (rst),
    .PS2_code       (ps2_code),
    .PS2_code_ready (ps2_ready),
    .PS2_make_code  (ps2_make),
    .Key_read       (key_read),
    .Clear_overflow (clear_ovf),
    .Key_code       (key_code),
    .Key_caps       (key_caps),
    .Key_valid      (key_valid),
    .Key_count      (key_count),
    .Shift_caps     (shift_caps),
    .Overflow       (overflow)
  );

  ps2_key_queue #(.DEPTH(DEPTH), .REPEAT_FILTER(0)) dut_nf (
    .Clock_50       (clk),
    .Reset          (rst),
    .PS2_code       (ps2_code),
    .PS2_code_ready (ps2_ready),
    .PS2_make_code  (ps2_make),
    .Key_read       (nf_read),
    .Clear_overflow (clear_ovf),
    .Key_code       (nf_code),
    .Key_caps       (nf_caps),
    .Key_valid      (nf_valid),
    .Key_count      (nf_count),
    .Shift_caps     (nf_shift),
    .Overflow       (nf_ovf)
  );

  // ---------------------------------------------------------------------------
  // Comparison bookkeeping
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: key-event level, updated at each rising edge
  // ---------------------------------------------------------------------------
  logic [8:0] mdl_q[$];
  bit         m_shift = 1'b0;
  bit         m_ovf   = 1'b0;
  logic [7:0] m_last  = 8'h00;
  bit         ev_pend = 1'b0;
  bit         ev_make = 1'b0;
  logic [7:0] ev_code = 8'h00;
  bit         rdy_prev = 1'b0;
  bit         m_pop, m_push, m_drop;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mdl_q.delete();
      m_shift  = 1'b0;
      m_ovf    = 1'b0;
      m_last   = 8'h00;
      ev_pend  = 1'b0;
      rdy_prev = 1'b0;
    end else begin
      m_pop  = key_read && (mdl_q.size() != 0);
      m_push = 1'b0;
      m_drop = 1'b0;
      if (ev_pend) begin
        if (ev_make && ev_code == 8'h12)      m_shift = 1'b1;
        else if (ev_make && ev_code == 8'h59) m_shift = 1'b0;
        else if (!ev_make) begin
          if (ev_code == m_last) m_last = 8'h00;
        end else if (!(m_last != 8'h00 && ev_code == m_last)) begin
          if (mdl_q.size() < DEPTH || m_pop) m_push = 1'b1;
          else                               m_drop = 1'b1;
        end
      end
      if (m_pop) void'(mdl_q.pop_front());
      if (m_push) begin
        mdl_q.push_back({m_shift, ev_code});
        m_last = ev_code;
      end
      if (m_drop)         m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
      // A code seen on a ready edge in this cycle is evaluated in the next one.
      ev_pend  = ps2_ready && !rdy_prev;
      ev_code  = ps2_code;
      ev_make  = ps2_make;
      rdy_prev = ps2_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compare the DUT's outputs with the model on each falling edge
  // ---------------------------------------------------------------------------
  bit mon_en = 1'b0;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("mon_count", 32'(key_count), 32'(mdl_q.size()));
      check("mon_valid", 32'(key_valid), 32'(mdl_q.size() != 0));
      check("mon_overflow", 32'(overflow), 32'(m_ovf));
      check("mon_shift", 32'(shift_caps), 32'(m_shift));
      if (key_valid && mdl_q.size() != 0) begin
        check("mon_head_code", 32'(key_code), 32'(mdl_q[0][7:0]));
        check("mon_head_caps", 32'(key_caps), 32'(mdl_q[0][8]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ps2_ready = 1'b0; key_read = 1'b0; clear_ovf = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(key_count), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'h00);
    check("rst_caps", 32'(key_caps), 32'd0);
    check("rst_shift", 32'(shift_caps), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // A code is held for 4 cycles: cycle 0 raises ready, cycle 1 is the
  // evaluation cycle. rdm/clm choose Key_read/Clear_overflow per cycle; rnd
  // picks them randomly instead.
  task automatic send(input logic [7:0] c, input logic mk, input logic [3:0] rdm,
                      input logic [3:0] clm, input bit rnd);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        ps2_code = c;
        ps2_make = mk;
      end
      ps2_ready = (i == 0);
      key_read  = rnd ? ($urandom_range(0, 7) == 0) : rdm[i];
      clear_ovf = rnd ? ($urandom_range(0, 15) == 0) : clm[i];
    end
    @(negedge clk);
    ps2_ready = 1'b0; key_read = 1'b0; clear_ovf = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_read = 1'b1;
    end
    @(negedge clk);
    key_read = 1'b0;
  endtask

  logic [7:0] pool [6] = '{8'h1C, 8'h1B, 8'h23, 8'h12, 8'h59, 8'h2B};

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    do_reset();
    mon_en = 1'b1;

    // Typematic repeats: filtered instance keeps one, unfiltered keeps three.
    for (int i = 0; i < 3; i++) send(8'h1C, 1'b1, 4'b0, 4'b0, 1'b0);
    check("rep_filter_count", 32'(key_count), 32'd1);
    check("rep_filter_code", 32'(key_code), 32'h1C);
    check("rep_nofilter_count", 32'(nf_count), 32'd3);

    // Push latency: edge in N, invisible in N+1, visible in N+2.
    do_reset();
    @(negedge clk);
    ps2_code = 8'h1C; ps2_make = 1'b1; ps2_ready = 1'b1;
    @(negedge clk);
    ps2_ready = 1'b0;
    check("lat_n1_valid", 32'(key_valid), 32'd0);
    @(negedge clk);
    check("lat_n2_valid", 32'(key_valid), 32'd1);
    check("lat_n2_code", 32'(key_code), 32'h1C);
    check("lat_n2_caps", 32'(key_caps), 32'd0);
    check("lat_n2_count", 32'(key_count), 32'd1);
    pop_n(1);
    check("lat_pop_count", 32'(key_count), 32'd0);

    // Shift then press / release / press gives two caps entries.
    do_reset();
    send(8'h12, 1'b1, 4'b0, 4'b0, 1'b0);
    send(8'h1C, 1'b1, 4'b0, 4'b0, 1'b0);
    send(8'h1C, 1'b0, 4'b0, 4'b0, 1'b0);
    send(8'h1C, 1'b1, 4'b0, 4'b0, 1'b0);
    check("shift_count", 32'(key_count), 32'd2);
    check("shift_caps_mode", 32'(shift_caps), 32'd1);
    check("shift_head", 32'({key_caps, key_code}), 32'h11C);
    pop_n(1);
    check("shift_second", 32'({key_caps, key_code}), 32'h11C);
    pop_n(1);
    send(8'h59, 1'b1, 4'b0, 4'b0, 1'b0);
    check("rshift_caps_mode", 32'(shift_caps), 32'd0);
    check("rshift_not_queued", 32'(key_count), 32'd0);

    // Read on an empty queue is ignored.
    pop_n(3);
    check("empty_read_count", 32'(key_count), 32'd0);
    check("empty_read_valid", 32'(key_valid), 32'd0);

    // Fill and overflow.
    do_reset();
    for (int i = 0; i < 17; i++) send(8'h20 + 8'(i), 1'b1, 4'b0, 4'b0, 1'b0);
    check("full_count", 32'(key_count), 32'd16);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_head", 32'(key_code), 32'h20);
    // A new overflow in the same cycle as a clear keeps the flag set.
    send(8'h31, 1'b1, 4'b0, 4'b0010, 1'b0);
    check("ovf_clr_collide", 32'(overflow), 32'd1);
    @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // At full, a pop during the evaluation cycle lets the push through.
    send(8'h40, 1'b1, 4'b0010, 4'b0, 1'b0);
    check("full_pushpop_count", 32'(key_count), 32'd16);
    check("full_pushpop_ovf", 32'(overflow), 32'd0);
    pop_n(15);
    check("full_pushpop_tail", 32'(key_code), 32'h40);
    check("full_pushpop_left", 32'(key_count), 32'd1);
    pop_n(1);

    // Reset during the evaluation cycle discards the pending code.
    do_reset();
    @(negedge clk);
    ps2_code = 8'h1C; ps2_make = 1'b1; ps2_ready = 1'b1;
    @(negedge clk);
    ps2_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("eval_rst_count", 32'(key_count), 32'd0);
    check("eval_rst_valid", 32'(key_valid), 32'd0);
    send(8'h1C, 1'b1, 4'b0, 4'b0, 1'b0);
    check("eval_rst_after", 32'(key_count), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      send(pool[$urandom_range(0, 5)], ($urandom_range(0, 3) != 0), 4'b0, 4'b0, 1'b1);
    end
    pop_n(DEPTH + 2);
    check("rand_drain_count", 32'(key_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
